// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: shared encodings and register map for the LED sequencer
package led_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;
  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_SEED   = 2'd3;
  function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [1:0] off);
    return base + {6'b0, off};
  endfunction
endpackage

// File: rtl/led_seq_timebase.sv
// led_seq_timebase: prescaler plus step counter producing one step pulse per (period+1)*DIV cycles
module led_seq_timebase #(
  parameter int DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] period,
  output logic       step
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pre_cnt;
  logic [7:0]    step_cnt;
  logic          pre_tick;
  assign pre_tick = en && pre_cnt == PW'(DIV - 1);
  assign step = pre_tick && step_cnt == period;
  // counters hold at zero while disabled or cleared, otherwise wrap at their limits
  always_ff @(posedge clk) begin
    if (rst || clear || !en) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pre_cnt <= pre_tick ? '0 : pre_cnt + 1'b1;
      if (pre_tick) step_cnt <= step ? '0 : step_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: CPU-programmable LED pattern engine feeding the LEDS peripheral write port
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h0A,
  parameter int          DIV       = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       write_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       led_we,
  output logic [7:0] led_din,
  output logic       busy
);
  state_t     state, state_nxt;
  mode_t      mode;
  dir_t       dir, dir_nxt;
  logic [7:0] period, seed, cur, cur_nxt, led_nxt;
  logic       led_we_nxt, step, active, due, do_step, defer;
  logic       wr_led, wr_ctrl, wr_period, wr_seed, start, stop;
  assign wr_led    = write_en && addr == reg_addr(BASE_ADDR, OFF_LED);
  assign wr_ctrl   = write_en && addr == reg_addr(BASE_ADDR, OFF_CTRL);
  assign wr_period = write_en && addr == reg_addr(BASE_ADDR, OFF_PERIOD);
  assign wr_seed   = write_en && addr == reg_addr(BASE_ADDR, OFF_SEED);
  assign start     = wr_ctrl && din[1:0] != 2'b00;
  assign stop      = wr_ctrl && din[1:0] == 2'b00;
  assign active    = state != IDLE;
  assign busy      = active;
  // a step is owed either from the timebase or from a deferral; a CPU LED write pushes it back
  assign due       = active && (step || state == PEND);
  assign do_step   = due && !wr_ctrl && !wr_led;
  assign defer     = due && wr_led;
  led_seq_timebase #(.DIV(DIV)) u_timebase (
    .clk    (clk),
    .rst    (rst),
    .clear  (start || wr_period),
    .en     (active),
    .period (period),
    .step   (step)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: control writes dominate, otherwise a collided step parks in PEND
  always_comb begin
    state_nxt = start ? RUN : (stop || !active) ? IDLE : defer ? PEND : RUN;
  end
  // next pattern value and LED write strobe; CPU LED write beats a step
  always_comb begin
    cur_nxt    = cur;
    dir_nxt    = dir;
    led_we_nxt = 1'b0;
    led_nxt    = led_din;
    if (start) begin
      cur_nxt    = seed;
      dir_nxt    = DIR_LEFT;
      led_we_nxt = 1'b1;
      led_nxt    = seed;
    end else if (wr_led) begin
      cur_nxt    = active ? din : cur;
      led_we_nxt = 1'b1;
      led_nxt    = din;
    end else if (do_step) begin
      led_we_nxt = 1'b1;
      case (mode)
        MODE_BLINK:  led_nxt = led_din == 8'h00 ? cur : 8'h00;
        MODE_ROTATE: begin
          cur_nxt = {cur[6:0], cur[7]};
          led_nxt = cur_nxt;
        end
        MODE_BOUNCE: begin
          dir_nxt = (dir == DIR_LEFT && cur[7]) ? DIR_RIGHT :
                    (dir == DIR_RIGHT && cur[0]) ? DIR_LEFT : dir;
          cur_nxt = dir_nxt == DIR_LEFT ? cur << 1 : cur >> 1;
          led_nxt = cur_nxt;
        end
        default: led_we_nxt = 1'b0;
      endcase
    end
  end
  // configuration and pattern registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= MODE_OFF;
      period  <= '0;
      seed    <= '0;
      cur     <= '0;
      dir     <= DIR_LEFT;
      led_we  <= 1'b0;
      led_din <= '0;
    end else begin
      if (wr_ctrl) mode <= mode_t'(din[1:0]);
      if (wr_period) period <= din;
      if (wr_seed) seed <= din;
      cur     <= cur_nxt;
      dir     <= dir_nxt;
      led_we  <= led_we_nxt;
      led_din <= led_nxt;
    end
  end
  // register readback
  always_comb begin
    dout = addr == reg_addr(BASE_ADDR, OFF_LED)    ? led_din :
           addr == reg_addr(BASE_ADDR, OFF_CTRL)   ? {6'b0, mode} :
           addr == reg_addr(BASE_ADDR, OFF_PERIOD) ? period :
           addr == reg_addr(BASE_ADDR, OFF_SEED)   ? seed : 8'h00;
  end
endmodule
